// File: rtl/ps2_kbd_matrix.sv
// PS/2 keyboard front end for the 6526 keyboard port: frame receiver, scancode decoder, 8x8 key matrix.
// Optional macro KBD_RESTORE_EN adds restore_n, driven directly by non-extended scancode 07 (F12).
`timescale 1ns/1ps
module ps2_kbd_matrix #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] col_sel,
    output logic [7:0] row_out,
    output logic [8:0] map_addr,
    output logic       map_rd,
    input  logic [6:0] map_data,
`ifdef KBD_RESTORE_EN
    output logic       restore_n,
`endif
    output logic       key_event,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {DEC_IDLE, DEC_LOOKUP, DEC_APPLY, DEC_SKIP} dec_state_t;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt;
    logic [FW-1:0] flt_cnt;
    logic          fall;
    logic          bit_in;

    rx_state_t     rx_state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_ok;
    logic          byte_valid;
    logic [TW-1:0] tmo_cnt;

    dec_state_t    dec_state;
    logic          ext, brk;
    logic [2:0]    skip_cnt;
    logic [6:0]    map_q;
    logic [63:0]   key;
    logic [5:0]    key_idx;
    logic [7:0]    rows_hit;

    assign bit_in  = data_sync[1];
    assign fall    = clk_filt & ~clk_sync[1] & (flt_cnt == FW'(FILTER_LEN - 1));
    assign key_idx = map_q[5:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            flt_cnt   <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // Timeout is a down-counter reloaded on every falling edge; terminal count aborts a partial frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_ok     <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            tmo_cnt    <= TW'(TIMEOUT_CYC);
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall)
                tmo_cnt <= TW'(TIMEOUT_CYC);
            else if (tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;

            if (fall) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (!bit_in) begin
                            rx_state <= RX_DATA;
                            bit_cnt  <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        shift <= {bit_in, shift[7:1]};
                        if (bit_cnt == 3'd7)
                            rx_state <= RX_PARITY;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                    RX_PARITY: begin
                        par_ok   <= ^{shift, bit_in};
                        rx_state <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (bit_in && par_ok)
                            byte_valid <= 1'b1;
                        else
                            frame_err <= 1'b1;
                        rx_state <= RX_IDLE;
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end else if (rx_state != RX_IDLE && tmo_cnt == '0) begin
                frame_err <= 1'b1;
                rx_state  <= RX_IDLE;
            end
        end
    end

    // The ROM answers the cycle after map_rd, so LOOKUP holds while map_rd is still high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_state <= DEC_IDLE;
            ext       <= 1'b0;
            brk       <= 1'b0;
            skip_cnt  <= '0;
            map_addr  <= '0;
            map_rd    <= 1'b0;
            map_q     <= '0;
            key       <= '0;
            key_event <= 1'b0;
`ifdef KBD_RESTORE_EN
            restore_n <= 1'b1;
`endif
        end else begin
            map_rd    <= 1'b0;
            key_event <= 1'b0;
            case (dec_state)
                DEC_IDLE: begin
                    if (byte_valid) begin
                        if (shift == 8'hE0) begin
                            ext <= 1'b1;
                        end else if (shift == 8'hF0) begin
                            brk <= 1'b1;
                        end else if (shift == 8'hE1) begin
                            skip_cnt  <= 3'd7;
                            dec_state <= DEC_SKIP;
                        end else if (shift inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
                            ext <= 1'b0;
                            brk <= 1'b0;
`ifdef KBD_RESTORE_EN
                        end else if (shift == 8'h07 && !ext) begin
                            restore_n <= brk;
                            if (restore_n != brk)
                                key_event <= 1'b1;
                            brk <= 1'b0;
`endif
                        end else begin
                            map_addr  <= {ext, shift};
                            map_rd    <= 1'b1;
                            dec_state <= DEC_LOOKUP;
                        end
                    end
                end
                DEC_LOOKUP: begin
                    if (!map_rd) begin
                        map_q     <= map_data;
                        dec_state <= DEC_APPLY;
                    end
                end
                DEC_APPLY: begin
                    if (map_q[6] && (key[key_idx] == brk)) begin
                        key[key_idx] <= ~brk;
                        key_event    <= 1'b1;
                    end
                    ext       <= 1'b0;
                    brk       <= 1'b0;
                    dec_state <= DEC_IDLE;
                end
                DEC_SKIP: begin
                    if (byte_valid) begin
                        if (skip_cnt == 3'd1) begin
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                            dec_state <= DEC_IDLE;
                        end else begin
                            skip_cnt <= skip_cnt - 1'b1;
                        end
                    end
                end
                default: dec_state <= DEC_IDLE;
            endcase
        end
    end

    always_comb begin
        rows_hit = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (!col_sel[c] && key[c*8 + r])
                    rows_hit[r] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            row_out <= 8'hFF;
        else
            row_out <= ~rows_hit;
    end
endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Directed bench for ps2_kbd_matrix: ROM lookups scored through an expected-address queue.
`timescale 1ns/1ps
module tb_ps2_kbd_matrix;
    localparam int TMO = 600;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ps2_clk, ps2_data;
    logic [7:0] col_sel;
    logic [7:0] row_out;
    logic [8:0] map_addr;
    logic       map_rd;
    logic [6:0] map_data;
    logic       key_event, frame_err;
`ifdef KBD_RESTORE_EN
    logic       restore_n;
`endif

    int vectors = 0;
    int miscompares = 0;
    int ke_cnt = 0;
    int fe_cnt = 0;
    logic [8:0] exp_q[$];
    logic [6:0] rom [0:511];

    ps2_kbd_matrix #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .col_sel(col_sel), .row_out(row_out), .map_addr(map_addr), .map_rd(map_rd),
        .map_data(map_data),
`ifdef KBD_RESTORE_EN
        .restore_n(restore_n),
`endif
        .key_event(key_event), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (map_rd) map_data <= rom[map_addr];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (key_event) ke_cnt++;
            if (frame_err) fe_cnt++;
            if (map_rd) begin
                check("map_rd_pending", 16'(exp_q.size() > 0), 16'd1);
                if (exp_q.size() > 0) check("map_addr", 16'(map_addr), 16'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (20) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(posedge clk);
            ps2_clk = 1'b1;
        end
        repeat (40) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    task automatic check_rows(input string tag, input logic [7:0] sel, input logic [7:0] exp);
        col_sel = sel;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(tag, 16'(row_out), 16'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ke0, fe0;
        for (int i = 0; i < 512; i++) rom[i] = 7'h00;
        rom[9'h01C] = {1'b1, 3'd1, 3'd2};
        rom[9'h175] = {1'b1, 3'd0, 3'd7};
        map_data = 7'h00;
        reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; col_sel = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_row_out", 16'(row_out), 16'hFF);
        check("rst_map_rd", 16'(map_rd), 16'h0);
        check("rst_map_addr", 16'(map_addr), 16'h0);
        check("rst_key_event", 16'(key_event), 16'h0);
        check("rst_frame_err", 16'(frame_err), 16'h0);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);

        // make 1C
        ke0 = ke_cnt;
        exp_q.push_back(9'h01C);
        send(8'h1C);
        check("make1c_ke", 16'(ke_cnt - ke0), 16'd1);
        check_rows("make1c_fd", 8'hFD, 8'hFB);
        check_rows("make1c_fe", 8'hFE, 8'hFF);

        // break 1C
        ke0 = ke_cnt;
        send(8'hF0);
        exp_q.push_back(9'h01C);
        send(8'h1C);
        check("brk1c_ke", 16'(ke_cnt - ke0), 16'd1);
        check_rows("brk1c_fd", 8'hFD, 8'hFF);

        // extended 75, then plain 75 with invalid ROM entry, then repeat make
        ke0 = ke_cnt;
        send(8'hE0);
        exp_q.push_back(9'h175);
        send(8'h75);
        check("ext75_ke", 16'(ke_cnt - ke0), 16'd1);
        check_rows("ext75_fe", 8'hFE, 8'h7F);
        ke0 = ke_cnt;
        exp_q.push_back(9'h075);
        send(8'h75);
        check("plain75_ke", 16'(ke_cnt - ke0), 16'd0);
        check_rows("plain75_fe", 8'hFE, 8'h7F);
        ke0 = ke_cnt;
        send(8'hE0);
        exp_q.push_back(9'h175);
        send(8'h75);
        check("repress_ke", 16'(ke_cnt - ke0), 16'd0);

        // parity error, then good frame
        ke0 = ke_cnt; fe0 = fe_cnt;
        send_bits(8'h1C, 1'b1, 11);
        check("par_fe", 16'(fe_cnt - fe0), 16'd1);
        check("par_ke", 16'(ke_cnt - ke0), 16'd0);
        check_rows("par_fd", 8'hFD, 8'hFF);
        exp_q.push_back(9'h01C);
        send(8'h1C);
        check("after_par_ke", 16'(ke_cnt - ke0), 16'd1);
        check_rows("after_par_fd", 8'hFD, 8'hFB);
        check_rows("all_cols", 8'h00, 8'h7B);

        // E1 prefix swallows exactly seven bytes
        ke0 = ke_cnt;
        send(8'hE1);
        for (int i = 0; i < 7; i++) send(8'h1C);
        check("e1_skip_q", 16'(exp_q.size()), 16'd0);
        exp_q.push_back(9'h01C);
        send(8'h1C);
        check("e1_after_ke", 16'(ke_cnt - ke0), 16'd0);
        check("e1_after_q", 16'(exp_q.size()), 16'd0);

        // timeout on partial frame
        fe0 = fe_cnt;
        send_bits(8'h1C, 1'b0, 5);
        repeat (TMO + 5) @(posedge clk);
        check("tmo_fe", 16'(fe_cnt - fe0), 16'd1);
        ke0 = ke_cnt;
        send(8'hF0);
        exp_q.push_back(9'h01C);
        send(8'h1C);
        check("after_tmo_ke", 16'(ke_cnt - ke0), 16'd1);
        check_rows("after_tmo_fd", 8'hFD, 8'hFF);
        check("after_tmo_fe", 16'(fe_cnt - fe0), 16'd1);

        // reset mid-frame with a key held
        exp_q.push_back(9'h01C);
        send(8'h1C);
        check_rows("held_fd", 8'hFD, 8'hFB);
        send_bits(8'h3A, 1'b0, 4);
        ke0 = ke_cnt;
        #3 reset_n = 1'b0;
        #1 check("rst_async_row", 16'(row_out), 16'hFF);
        ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_ke", 16'(ke_cnt - ke0), 16'd0);
        check_rows("rst_cleared", 8'h00, 8'hFF);
        exp_q.push_back(9'h01C);
        send(8'h1C);
        check_rows("post_rst_fd", 8'hFD, 8'hFB);
        check("post_rst_ke", 16'(ke_cnt - ke0), 16'd1);

`ifdef KBD_RESTORE_EN
        check("restore_rst", 16'(restore_n), 16'd1);
        ke0 = ke_cnt;
        send(8'h07);
        check("restore_make", 16'(restore_n), 16'd0);
        check("restore_make_ke", 16'(ke_cnt - ke0), 16'd1);
        send(8'hF0);
        send(8'h07);
        check("restore_brk", 16'(restore_n), 16'd1);
        check("restore_brk_ke", 16'(ke_cnt - ke0), 16'd2);
        check_rows("restore_matrix", 8'h00, 8'hFB);
`else
        ke0 = ke_cnt;
        exp_q.push_back(9'h007);
        send(8'h07);
        check("f12_rom_ke", 16'(ke_cnt - ke0), 16'd0);
`endif

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
